// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and sizing helper for the 4-way round-robin arbiter.
package rr_arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } arb_state_e;

  function automatic int hold_w(input int max_hold);
    return $clog2(max_hold);
  endfunction
endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the arbiter feeding the 2-to-4 decoder.
interface rr_arbiter_4_if;
  import rr_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;

  modport master (output req, input  grant_idx, input  grant_valid);
  modport slave  (input  req, output grant_idx, output grant_valid);
endinterface

// File: rtl/rr_pick_4.sv
// Rotating-priority picker: first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  logic [IDX_W-1:0] cand;

  // Scan from farthest to nearest so the closest hit to ptr overwrites the rest.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered grant index/valid.
// Optional per-grant hold limit enabled by RR_ARB_HOLD_LIMIT_EN (uses MAX_HOLD).
module rr_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_arbiter_4_if.slave  bus
);
  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             vld_q, vld_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             take;

  rr_pick_4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = hold_w(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]  others;
  logic              force_sw;

  assign others   = bus.req & ~(N_REQ'(1) << idx_q);
  assign force_sw = (cnt_q == HOLD_TOP) && (others != '0);
`else
  // MAX_HOLD has no effect without the hold limit.
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    take    = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        if (pick_found) begin
          state_d = GRANT;
          take    = 1'b1;
        end
      end
      GRANT: begin
        if (bus.req == '0) begin
          state_d = IDLE;
          vld_d   = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
        end else if (!bus.req[idx_q] || force_sw) begin
          take = 1'b1;
        end else if (cnt_q != HOLD_TOP) begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        end else if (!bus.req[idx_q]) begin
          take = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase

    // ptr = grant+1 makes the outgoing holder the last one scanned next time.
    if (take) begin
      idx_d = pick_idx;
      ptr_d = pick_idx + 1'b1;
      vld_d = 1'b1;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
`ifdef RR_ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = vld_q;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4 (hold-limit checks follow RR_ARB_HOLD_LIMIT_EN).
module tb_rr_arbiter_4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  rr_arbiter_4_if bus();

  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.req = 4'b0000;
    #3;
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b000)
      $display("FAIL reset_init got v=%b i=%0d want v=0 i=0", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    rst = 1'b0;
    bus.req = 4'b0100;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b110)
      $display("FAIL reset_pre_grant got v=%b i=%0d want v=1 i=2", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b000)
      $display("FAIL reset_async got v=%b i=%0d want v=0 i=0", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b1111;
    #2 rst = 1'b0;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b100)
      $display("FAIL reset_first_tie got v=%b i=%0d want v=1 i=0", bus.grant_valid, bus.grant_idx);
    else n_pass++;
  endtask

  // Holder 0 on entry; pulse the holder low each grant -> 1,2,3,0.
  task automatic test_rotation();
    logic [1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] cur = 2'd0;
    for (int k = 0; k < 4; k++) begin
      bus.req = 4'b1111 & ~(4'b0001 << cur);
      step();
      n_total++;
      if ({bus.grant_valid, bus.grant_idx} !== {1'b1, exp_seq[k]})
        $display("FAIL rotation_switch%0d got v=%b i=%0d want v=1 i=%0d", k, bus.grant_valid, bus.grant_idx, exp_seq[k]);
      else n_pass++;
      bus.req = 4'b1111;
      step();
      n_total++;
      if ({bus.grant_valid, bus.grant_idx} !== {1'b1, exp_seq[k]})
        $display("FAIL rotation_hold%0d got v=%b i=%0d want v=1 i=%0d", k, bus.grant_valid, bus.grant_idx, exp_seq[k]);
      else n_pass++;
      cur = exp_seq[k];
    end
  endtask

  task automatic test_handover();
    bus.req = 4'b0010;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b101)
      $display("FAIL handover_grant1 got v=%b i=%0d want v=1 i=1", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b1000;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b111)
      $display("FAIL handover_to3 got v=%b i=%0d want v=1 i=3", bus.grant_valid, bus.grant_idx);
    else n_pass++;
  endtask

  task automatic test_idle_return();
    bus.req = 4'b0100;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b110)
      $display("FAIL idle_grant2 got v=%b i=%0d want v=1 i=2", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b0000;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b010)
      $display("FAIL idle_drop got v=%b i=%0d want v=0 i=2", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b0001;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b100)
      $display("FAIL idle_regrant0 got v=%b i=%0d want v=1 i=0", bus.grant_valid, bus.grant_idx);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bus.req = 4'b0100;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b110)
      $display("FAIL wrap_grant2 got v=%b i=%0d want v=1 i=2", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b1001;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b111)
      $display("FAIL wrap_ptr3 got v=%b i=%0d want v=1 i=3", bus.grant_valid, bus.grant_idx);
    else n_pass++;
    bus.req = 4'b0001;
    step();
    n_total++;
    if ({bus.grant_valid, bus.grant_idx} !== 3'b100)
      $display("FAIL wrap_to0 got v=%b i=%0d want v=1 i=0", bus.grant_valid, bus.grant_idx);
    else n_pass++;
  endtask

  // Grant 3 first so ptr=0, then 4'b0011 hands over to 0 with a fresh hold count.
  task automatic test_hold_limit();
    logic [1:0] exp_i;
    bus.req = 4'b1000;
    step();
    bus.req = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      step();
`ifdef RR_ARB_HOLD_LIMIT_EN
      exp_i = (c >= 4 && c < 8) ? 2'd1 : 2'd0;
`else
      exp_i = 2'd0;
`endif
      n_total++;
      if ({bus.grant_valid, bus.grant_idx} !== {1'b1, exp_i})
        $display("FAIL hold_pair_c%0d got v=%b i=%0d want v=1 i=%0d", c, bus.grant_valid, bus.grant_idx, exp_i);
      else n_pass++;
    end
    bus.req = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      step();
      n_total++;
      if ({bus.grant_valid, bus.grant_idx} !== 3'b100)
        $display("FAIL hold_alone_c%0d got v=%b i=%0d want v=1 i=0", c, bus.grant_valid, bus.grant_idx);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req = 4'b0000;
    test_reset();
    test_rotation();
    test_handover();
    test_idle_return();
    test_wrap();
    test_hold_limit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
